// File: rtl/driver_input_conditioner.sv
// Driver input conditioner: synchronizes and debounces the speed buttons,
// turns presses into single-cycle request pulses with auto-repeat and
// mutual lockout, and filters the driver-awareness sensor code.

// Per-button lane: 2-FF sync, debounce, pulse/repeat FSM.
module dic_button #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    input  logic lock_i,   // both debounced buttons high
    input  logic clear_i,  // both debounced buttons low
    output logic deb_o,
    output logic pulse_o
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RP_M  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RP_W  = $clog2(RP_M + 1);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

    logic [1:0]      sync_q;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] dcnt_q, dcnt_d;
    state_t          state_q, state_d;
    logic [RP_W-1:0] rcnt_q, rcnt_d;
    logic            pulse_q, pulse_d;

    // Debounce: count consecutive samples that disagree with the debounced state.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (dcnt_q + 1'b1 >= DB_MAX) begin
                deb_d  = ~deb_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Pulse FSM: first pulse on press, delayed repeat, then periodic repeat.
    // Release wins over a repeat landing on the same edge; lockout wins over all.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                rcnt_d = '0;
                if (lock_i) begin
                    state_d = LOCK;
                end else if (deb_q) begin
                    state_d = HOLD;
                    pulse_d = 1'b1;
                end
            end
            HOLD: begin
                if (lock_i) begin
                    state_d = LOCK;
                    rcnt_d  = '0;
                end else if (!deb_q) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q + 1'b1 >= RP_DELAY) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (lock_i) begin
                    state_d = LOCK;
                    rcnt_d  = '0;
                end else if (!deb_q) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q + 1'b1 >= RP_RATE) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                rcnt_d = '0;
                if (clear_i) state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            state_q <= IDLE;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign deb_o   = deb_q;
    assign pulse_o = pulse_q;
endmodule

module driver_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4,
    parameter int unsigned AWARE_STABLE    = 3,
    parameter int unsigned ALERT_LEVEL     = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic [2:0] awareness_raw,
    output logic       speed_up,
    output logic       speed_down,
    output logic [2:0] awareness,
    output logic       alert
);
    localparam int unsigned AW_W = $clog2(AWARE_STABLE + 1);
    localparam logic [AW_W-1:0] AW_MAX = AW_W'(AWARE_STABLE);

    logic [1:0] raw, deb, pulse;
    logic       lock, clear;

    assign raw   = {btn_down_raw, btn_up_raw};
    assign lock  = &deb;
    assign clear = ~|deb;

    // Lane 0 = speed up, lane 1 = speed down.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        dic_button #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_btn (
            .clock  (clock),
            .reset_n(reset_n),
            .raw_i  (raw[g]),
            .lock_i (lock),
            .clear_i(clear),
            .deb_o  (deb[g]),
            .pulse_o(pulse[g])
        );
    end

    assign speed_up   = pulse[0];
    assign speed_down = pulse[1];

    logic [2:0]      as1_q, as2_q;
    logic [2:0]      cand_q, cand_d;
    logic [AW_W-1:0] acnt_q, acnt_d;
    logic [2:0]      aw_q, aw_d;
    logic            alert_q, alert_d;

    // Awareness filter: publish the candidate once it has been seen
    // AWARE_STABLE times in a row; count saturates at the threshold.
    always_comb begin
        cand_d = cand_q;
        acnt_d = acnt_q;
        aw_d   = aw_q;
        if (as2_q != cand_q) begin
            cand_d = as2_q;
            acnt_d = AW_W'(1);
        end else if (acnt_q < AW_MAX) begin
            acnt_d = acnt_q + 1'b1;
        end
        if (acnt_d >= AW_MAX) aw_d = cand_d;
        alert_d = (32'(aw_q) >= ALERT_LEVEL);
    end

    // Awareness sync, filter and alert registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            as1_q   <= '0;
            as2_q   <= '0;
            cand_q  <= '0;
            acnt_q  <= '0;
            aw_q    <= '0;
            alert_q <= 1'b0;
        end else begin
            as1_q   <= awareness_raw;
            as2_q   <= as1_q;
            cand_q  <= cand_d;
            acnt_q  <= acnt_d;
            aw_q    <= aw_d;
            alert_q <= alert_d;
        end
    end

    assign awareness = aw_q;
    assign alert     = alert_q;
endmodule

// File: tb/tb_driver_input_conditioner.sv
// Directed bench for driver_input_conditioner at default parameters.
// Edge r of a scenario is the r-th rising edge after its inputs were set;
// outputs are sampled on the falling edge that follows.
module tb_driver_input_conditioner;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_up_raw, btn_down_raw;
    logic [2:0] awareness_raw;
    logic       speed_up, speed_down, alert;
    logic [2:0] awareness;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    driver_input_conditioner dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .awareness_raw(awareness_raw),
        .speed_up     (speed_up),
        .speed_down   (speed_down),
        .awareness    (awareness),
        .alert        (alert)
    );

    task automatic chk(input string tag, input int rel, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, rel, got, exp);
        end
    endtask

    task automatic tick_btn(input string tag, input int rel, input logic eu, input logic ed);
        @(negedge clock);
        chk({tag, ".up"}, rel, int'(speed_up), int'(eu));
        chk({tag, ".dn"}, rel, int'(speed_down), int'(ed));
    endtask

    task automatic tick_aw(input string tag, input int rel, input int ea, input int eal);
        @(negedge clock);
        chk({tag, ".aw"}, rel, int'(awareness), ea);
        chk({tag, ".alert"}, rel, int'(alert), eal);
    endtask

    function automatic logic bnc(input int e);
        return (e <= 12) && (((e - 1) / 2) % 2 == 0);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; btn_up_raw = 1'b0; btn_down_raw = 1'b0; awareness_raw = 3'b000;
        repeat (3) @(negedge clock);
        chk("rst.up", 0, int'(speed_up), 0);
        chk("rst.dn", 0, int'(speed_down), 0);
        chk("rst.aw", 0, int'(awareness), 0);
        chk("rst.alert", 0, int'(alert), 0);
        reset_n = 1'b1;
        for (int r = 1; r <= 8; r++) tick_btn("idle", r, 1'b0, 1'b0);

        // Clean press: raw high edges 1..10 -> single pulse after edge 7.
        btn_up_raw = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            tick_btn("press", r, r == 7, 1'b0);
            if (r == 10) btn_up_raw = 1'b0;
        end

        // Bounce: toggles every 2 cycles for 12 cycles, then low.
        btn_down_raw = bnc(1);
        for (int r = 1; r <= 20; r++) begin
            tick_btn("bounce", r, 1'b0, 1'b0);
            btn_down_raw = bnc(r + 1);
        end
        btn_down_raw = 1'b1;
        for (int r = 1; r <= 24; r++) begin
            tick_btn("bhold", r, 1'b0, r == 7);
            if (r == 12) btn_down_raw = 1'b0;
        end

        // Auto-repeat: held edges 1..40.
        btn_up_raw = 1'b1;
        for (int r = 1; r <= 50; r++) begin
            tick_btn("repeat", r, r inside {7, 23, 27, 31, 35, 39, 43}, 1'b0);
            if (r == 40) btn_up_raw = 1'b0;
        end

        // Lockout: up pulses once, down joins, down released, then up released.
        btn_up_raw = 1'b1;
        for (int r = 1; r <= 75; r++) begin
            tick_btn("lock", r, r == 7, 1'b0);
            if (r == 10) btn_down_raw = 1'b1;
            if (r == 40) btn_down_raw = 1'b0;
            if (r == 60) btn_up_raw = 1'b0;
        end
        btn_down_raw = 1'b1;
        for (int r = 1; r <= 24; r++) begin
            tick_btn("repress", r, 1'b0, r == 7);
            if (r == 12) btn_down_raw = 1'b0;
        end

        // Awareness: 2-cycle glitch rejected, then clean changes.
        awareness_raw = 3'b101;
        for (int r = 1; r <= 10; r++) begin
            tick_aw("glitch", r, 0, 0);
            if (r == 2) awareness_raw = 3'b000;
        end
        awareness_raw = 3'b011;
        for (int r = 1; r <= 8; r++) tick_aw("aw3", r, (r >= 5) ? 3 : 0, 0);
        awareness_raw = 3'b101;
        for (int r = 1; r <= 8; r++) tick_aw("aw5", r, (r >= 5) ? 5 : 3, (r >= 6) ? 1 : 0);

        // Async reset mid-REPEAT, right after the edge-31 pulse.
        btn_up_raw = 1'b1;
        for (int r = 1; r <= 31; r++) tick_btn("rep2", r, r inside {7, 23, 27, 31}, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.up", 31, int'(speed_up), 0);
        chk("arst.dn", 31, int'(speed_down), 0);
        chk("arst.aw", 31, int'(awareness), 0);
        chk("arst.alert", 31, int'(alert), 0);
        for (int r = 1; r <= 2; r++) tick_btn("inrst", r, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            tick_btn("post", r, r == 7, 1'b0);
            chk("post.aw", r, int'(awareness), (r >= 5) ? 5 : 0);
            chk("post.alert", r, int'(alert), (r >= 6) ? 1 : 0);
        end
        btn_up_raw = 1'b0;
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/driver_input_conditioner.md
Name: driver_input_conditioner

Overview:
- Front-end stage directly upstream of the cruise Control block.
- Cleans raw driver buttons into single-cycle speed_up / speed_down request pulses, with auto-repeat while a button is held.
- Filters the raw 3-bit driver-awareness sensor code into a stable awareness value, and flags high-risk awareness levels.
- All outputs are registered and connect directly to the Control inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive differing synchronized samples needed to flip a debounced button state.
- REPEAT_DELAY, 16: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_RATE, 4: cycles between subsequent auto-repeat pulses.
- AWARE_STABLE, 3: consecutive identical synchronized awareness samples needed to update the output.
- ALERT_LEVEL, 5: alert asserts when filtered awareness >= this value.

Ports:
- clock, input, 1: system clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- btn_up_raw, input, 1: raw speed-up button (asynchronous, may bounce).
- btn_down_raw, input, 1: raw speed-down button (asynchronous, may bounce).
- awareness_raw, input, 3: raw awareness sensor code (asynchronous).
- speed_up, output, 1: one-cycle speed-up request to Control.
- speed_down, output, 1: one-cycle speed-down request to Control.
- awareness, output, 3: filtered awareness code to Control.
- alert, output, 1: high while awareness >= ALERT_LEVEL.

Behaviour:
- Reset (reset_n low): asynchronously clears all state.
  - Outputs: speed_up=0, speed_down=0, awareness=3'b000, alert=0.
  - Internal: synchronizers 0, debounced states 0, all counters 0, both FSMs IDLE.
- Reset mid-hold: no pulse is emitted during or on release of reset. A button still held after reset is treated as a fresh press.
- Synchronization: 2-FF synchronizer on each raw bit.
- Debounce (per button):
  - The counter increments while the synchronized value differs from the debounced state, and clears on any match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
- Press latency: with the raw input first sampled high at edge 1 and held, speed_up is high for exactly one cycle after edge DEBOUNCE_CYCLES+3 (edge 7 at default parameters).
- Pulse FSM (per button): states IDLE, HOLD, REPEAT, LOCK.
  - IDLE -> HOLD on debounced rise; emit one pulse; clear the repeat counter.
  - HOLD: on the edge that is REPEAT_DELAY cycles after the first pulse, emit a pulse and go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_RATE cycles.
  - HOLD/REPEAT -> IDLE on debounced fall. No pulse is emitted on release, including when the fall and a scheduled repeat pulse land on the same edge.
- Mutual lockout:
  - If both debounced states are high, both FSMs enter LOCK and both outputs are 0.
  - LOCK exits to IDLE only once both debounced states are low. A button still held on exit must be released and re-pressed.
  - If both debounced states rise on the same edge, go straight to LOCK with no pulse.
- Pulse rule: speed_up and speed_down are never high in the same cycle.
- Awareness filter:
  - A candidate register holds the last synchronized sample, and a counter tracks how many consecutive samples equal it.
  - When the counter reaches AWARE_STABLE, the candidate is copied to awareness.
  - Any differing sample reloads the candidate and sets the count to 1.
  - Total latency for a clean change is AWARE_STABLE+2 edges.
  - Glitches shorter than AWARE_STABLE cycles never reach the output.
- Alert: alert is registered from the filtered awareness value, so it updates one edge after awareness. Comparison is unsigned.
- Counter widths are sized from the parameters with $clog2. Counters saturate and never wrap.

Test Plan (default parameters):
- Clean press: btn_up_raw high for 10 cycles -> one speed_up pulse after edge 7; no other pulses; speed_down stays 0 throughout.
- Bounce rejection: btn_down_raw toggles every 2 cycles for 12 cycles, then low -> no speed_down pulse. Then held high -> single pulse 7 edges after the stable level begins.
- Auto-repeat: btn_up_raw high edges 1..40, then low -> speed_up pulses at edges 7, 23, 27, 31, 35, 39, 43 only.
- Lockout: up held and pulsed once, then btn_down_raw pressed:
  - No pulses on either output while both are held.
  - Releasing only down gives no pulse.
  - Releasing both and re-pressing down gives one speed_down pulse.
- Awareness filter:
  - Raw 000 -> 101 for 2 cycles -> back to 000: awareness stays 000, alert stays 0.
  - Raw 011 held: awareness becomes 011 after 5 edges, alert 0.
  - Raw 101 held: awareness becomes 101, alert becomes 1 one edge later.
- Async reset: reset_n pulled low mid-REPEAT, between edges -> all outputs 0 immediately. After release, with the button held, the first pulse comes 7 edges later.
